// File: rtl/l2_ic_resp.sv
// l2_ic_resp: L2-side responder for I-Cache block refills.
// Looks up the 2-way L2 arrays, fetches from memory on a miss, fills one way
// and returns the 128-bit block with a single-cycle l2_rdy pulse.
// Optional build macro: L2_EARLY_RESP_EN, which asserts l2_rdy in the FILL
// cycle of a miss instead of the cycle after it.
module l2_ic_resp (
  input  logic         clk,
  input  logic         rst,
  input  logic         irq,
  input  logic [27:0]  l2_addr,
  input  logic         l2_busy,
  output logic         ic_en,
  output logic         l2_rdy,
  output logic [127:0] data_wd_l2,
  output logic [8:0]   l2_index,
  input  logic [19:0]  l2_tag0_rd,
  input  logic [19:0]  l2_tag1_rd,
  input  logic [127:0] l2_data0_rd,
  input  logic [127:0] l2_data1_rd,
  input  logic         l2_lru,
  output logic         l2_block0_we,
  output logic         l2_block1_we,
  output logic [19:0]  l2_tag_wd,
  output logic [127:0] l2_data_wd,
  output logic         mem_req,
  output logic [27:0]  mem_addr,
  input  logic         mem_ack,
  input  logic [127:0] mem_rd_data
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_BUSY = 3'd1;
  localparam logic [2:0] S_LOOKUP    = 3'd2;
  localparam logic [2:0] S_COMPARE   = 3'd3;
  localparam logic [2:0] S_MEM_REQ   = 3'd4;
  localparam logic [2:0] S_FILL      = 3'd5;
  localparam logic [2:0] S_RESP      = 3'd6;
  localparam logic [2:0] S_HOLD      = 3'd7;

  logic [2:0]   state_q, state_d;
  logic [27:0]  addr_q, addr_d;
  logic [127:0] data_q, data_d;
  logic         victim_q, victim_d;   // way chosen for the fill (1 = way1)
  logic         drop_q, drop_d;       // requester let go before the response

  logic [19:0] tag_cmp;
  logic        hit0, hit1;

  // A way hits when its stored {valid, tag} equals {1, requested tag}.
  assign tag_cmp = {1'b1, addr_q[27:9]};
  assign hit0    = (l2_tag0_rd == tag_cmp);
  assign hit1    = (l2_tag1_rd == tag_cmp);

  // Next-state, address latch, returned-block and victim selection.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    victim_d = victim_q;
    drop_d   = drop_q;
    if (state_q == S_IDLE || state_q == S_WAIT_BUSY) drop_d = 1'b0;
    else if (!irq)                                   drop_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (irq) begin
          if (l2_busy) state_d = S_WAIT_BUSY;
          else begin
            state_d = S_LOOKUP;
            addr_d  = l2_addr;
          end
        end
      end
      S_WAIT_BUSY: begin
        if (!irq) state_d = S_IDLE;
        else if (!l2_busy) begin
          state_d = S_LOOKUP;
          addr_d  = l2_addr;
        end
      end
      S_LOOKUP: state_d = S_COMPARE;
      S_COMPARE: begin
        if (hit0 || hit1) begin
          data_d  = hit0 ? l2_data0_rd : l2_data1_rd;
          state_d = S_RESP;
        end else begin
          // Victim: first invalid way, otherwise the set's LRU mark.
          if (!l2_tag0_rd[19])      victim_d = 1'b0;
          else if (!l2_tag1_rd[19]) victim_d = 1'b1;
          else                      victim_d = l2_lru;
          state_d = S_MEM_REQ;
        end
      end
      S_MEM_REQ: begin
        if (mem_ack) begin
          data_d  = mem_rd_data;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
`ifdef L2_EARLY_RESP_EN
        state_d = drop_q ? S_IDLE : S_HOLD;
`else
        state_d = S_RESP;
`endif
      end
      S_RESP:  state_d = drop_q ? S_IDLE : S_HOLD;
      S_HOLD:  if (!irq) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything visible outside.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      victim_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      victim_q <= victim_d;
      drop_q   <= drop_d;
    end
  end

  // Outputs decode from registered state so reset silences them next cycle.
  always_comb begin
    ic_en        = (state_q != S_IDLE) && (state_q != S_WAIT_BUSY);
`ifdef L2_EARLY_RESP_EN
    l2_rdy       = ((state_q == S_RESP) || (state_q == S_FILL)) && !drop_q;
`else
    l2_rdy       = (state_q == S_RESP) && !drop_q;
`endif
    data_wd_l2   = data_q;
    l2_index     = addr_q[8:0];
    l2_block0_we = (state_q == S_FILL) && !victim_q;
    l2_block1_we = (state_q == S_FILL) && victim_q;
    l2_tag_wd    = (state_q == S_FILL) ? tag_cmp : 20'd0;
    l2_data_wd   = (state_q == S_FILL) ? data_q : 128'd0;
    mem_req      = (state_q == S_MEM_REQ);
    mem_addr     = (state_q == S_MEM_REQ) ? addr_q : 28'd0;
  end

endmodule

// File: tb/tb_l2_ic_resp.sv
// tb_l2_ic_resp: randomized scoreboard bench for l2_ic_resp with L2 array and
// memory models; a reference cache model predicts hit data and fills.
module tb_l2_ic_resp;
  logic clk = 1'b0;
  logic rst, irq, l2_busy, mem_ack, l2_lru;
  logic [27:0] l2_addr, mem_addr;
  logic ic_en, l2_rdy, we0, we1, mem_req;
  logic [127:0] data_wd_l2, l2_data_wd, mem_rd_data, d0_rd, d1_rd;
  logic [8:0] l2_index;
  logic [19:0] tag0_rd, tag1_rd, l2_tag_wd;

  always #5 clk = ~clk;

  l2_ic_resp dut (
    .clk(clk), .rst(rst), .irq(irq), .l2_addr(l2_addr), .l2_busy(l2_busy),
    .ic_en(ic_en), .l2_rdy(l2_rdy), .data_wd_l2(data_wd_l2), .l2_index(l2_index),
    .l2_tag0_rd(tag0_rd), .l2_tag1_rd(tag1_rd), .l2_data0_rd(d0_rd), .l2_data1_rd(d1_rd),
    .l2_lru(l2_lru), .l2_block0_we(we0), .l2_block1_we(we1), .l2_tag_wd(l2_tag_wd),
    .l2_data_wd(l2_data_wd), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rd_data(mem_rd_data)
  );

`ifdef L2_EARLY_RESP_EN
  localparam int MISS_LAT = 1;
`else
  localparam int MISS_LAT = 2;
`endif

  // Environment arrays (written by the DUT) and reference copies (written by prediction)
  logic [19:0]  e_tag0[512], e_tag1[512], r_tag0[512], r_tag1[512];
  logic [127:0] e_d0[512], e_d1[512], r_d0[512], r_d1[512];
  logic         lru_a[512];

  typedef struct { logic [127:0] data; bit hit; } rsp_t;
  typedef struct { logic way; logic [8:0] idx; logic [19:0] tag; logic [127:0] data; } fill_t;
  rsp_t  rq[$];
  fill_t fq[$];

  int checks = 0, passed = 0;
  bit resp_en = 1'b1;
  logic [27:0] cur_addr;
  bit cur_miss;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [127:0] mem_word(input logic [27:0] a);
    return {a, 4'h1, a, 4'h2, a, 4'h3, a, 4'h4};
  endfunction

  // Array read port: one-cycle registered read; writes from the DUT fill port.
  always @(posedge clk) begin
    tag0_rd <= e_tag0[l2_index];
    tag1_rd <= e_tag1[l2_index];
    d0_rd   <= e_d0[l2_index];
    d1_rd   <= e_d1[l2_index];
    l2_lru  <= lru_a[l2_index];
    if (we0) begin e_tag0[l2_index] <= l2_tag_wd; e_d0[l2_index] <= l2_data_wd; end
    if (we1) begin e_tag1[l2_index] <= l2_tag_wd; e_d1[l2_index] <= l2_data_wd; end
  end

  // Reference cache: decide hit/miss, expected block and fill from the rules.
  task automatic predict(input logic [27:0] a, input bit drop, output bit miss);
    logic [8:0] idx;
    logic [19:0] tg;
    rsp_t r;
    fill_t f;
    idx = a[8:0];
    tg = {1'b1, a[27:9]};
    miss = 0;
    if (r_tag0[idx] == tg) r.data = r_d0[idx];
    else if (r_tag1[idx] == tg) r.data = r_d1[idx];
    else begin
      miss = 1;
      r.data = mem_word(a);
      if (!r_tag0[idx][19]) f.way = 0;
      else if (!r_tag1[idx][19]) f.way = 1;
      else f.way = lru_a[idx];
      f.idx = idx; f.tag = tg; f.data = r.data;
      if (f.way) begin r_tag1[idx] = tg; r_d1[idx] = r.data; end
      else begin r_tag0[idx] = tg; r_d0[idx] = r.data; end
      fq.push_back(f);
    end
    r.hit = !miss;
    if (!drop) rq.push_back(r);
  endtask

  // Memory responder: random 0..5 cycle ack delay, data derived from address.
  initial begin
    mem_ack = 0;
    mem_rd_data = '0;
    forever begin
      @(posedge clk); #1;
      if (resp_en && mem_req) begin
        chk(cur_miss, "mem_req_on_miss", 128'(mem_req), 128'(cur_miss));
        chk(mem_addr == cur_addr, "mem_addr", 128'(mem_addr), 128'(cur_addr));
        repeat ($urandom % 6) begin @(posedge clk); #1; end
        mem_rd_data = mem_word(mem_addr);
        mem_ack = 1;
        @(posedge clk); #1;
        mem_ack = 0;
      end
    end
  end

  // Monitor: pops expected fills and responses, checks latency and hold stability.
  int en_age = 0, ack_age = 99;
  bit prev_en = 0, in_hold = 0;
  logic [127:0] hold_exp;
  always @(negedge clk) begin
    rsp_t e;
    fill_t f;
    if (rst) begin
      in_hold = 0; prev_en = 0; en_age = 0; ack_age = 99;
    end else begin
      if (ic_en) en_age = prev_en ? en_age + 1 : 0;
      prev_en = ic_en;
      if (mem_ack && mem_req) ack_age = 0; else ack_age++;
      if (we0 || we1) begin
        if (we0 && we1) chk(0, "one_we", {we1, we0}, 2'b01);
        else if (fq.size() == 0) chk(0, "unexpected_fill", {we1, we0}, 0);
        else begin
          f = fq.pop_front();
          chk({we1, l2_index, l2_tag_wd} == {f.way, f.idx, f.tag}, "fill_way_idx_tag",
              {we1, l2_index, l2_tag_wd}, {f.way, f.idx, f.tag});
          chk(l2_data_wd == f.data, "fill_data", l2_data_wd, f.data);
        end
      end
      if (l2_rdy) begin
        if (rq.size() == 0) chk(0, "unexpected_rdy", 1, 0);
        else begin
          e = rq.pop_front();
          chk(data_wd_l2 == e.data, "rdy_data", data_wd_l2, e.data);
          if (e.hit) chk(en_age == 2, "hit_latency", en_age, 2);
          else chk(ack_age == MISS_LAT, "miss_latency", ack_age, MISS_LAT);
          in_hold = 1;
          hold_exp = e.data;
        end
      end else if (in_hold) begin
        if (ic_en) chk(data_wd_l2 == hold_exp, "hold_data", data_wd_l2, hold_exp);
        else in_hold = 0;
      end
    end
  end

  task automatic do_req(input logic [27:0] a, input int busy, input int hold, input bit drop);
    bit m;
    int t;
    predict(a, drop, m);
    cur_addr = a;
    cur_miss = m;
    l2_addr = a;
    irq = 1;
    l2_busy = (busy > 0);
    if (busy > 0) begin
      repeat (busy) begin
        @(negedge clk);
        chk(!ic_en, "busy_no_grant", ic_en, 0);
      end
      l2_busy = 0;
    end
    @(negedge clk);
    chk(ic_en, "grant", ic_en, 1);
    l2_busy = $urandom % 2;   // must be ignored once granted
    if (drop) begin
      irq = 0;
      t = 0;
      while (ic_en && t < 300) begin @(negedge clk); t++; end
      chk(!ic_en, "drop_return_idle", ic_en, 0);
    end else begin
      t = 0;
      while (!l2_rdy && t < 300) begin @(negedge clk); t++; end
      chk(l2_rdy, "rdy_seen", l2_rdy, 1);
      repeat (hold) @(negedge clk);
      irq = 0;
      @(negedge clk);
      chk(!ic_en, "release", ic_en, 0);
    end
    l2_busy = 0;
  endtask

  initial begin
    int t;
    logic [27:0] a;
    int b;
    for (int i = 0; i < 512; i++) begin
      e_tag0[i] = {1'($urandom % 2), 19'($urandom % 4)};
      e_tag1[i] = {1'($urandom % 2), 19'($urandom % 4)};
      e_d0[i] = {$urandom, $urandom, $urandom, $urandom};
      e_d1[i] = {$urandom, $urandom, $urandom, $urandom};
      lru_a[i] = 1'($urandom % 2);
    end
    // Directed sets: hit way1 (way0 invalid), both invalid, both valid with lru=1
    e_tag0[6] = 20'h0; e_tag1[6] = {1'b1, 19'd9}; e_d1[6] = {16{8'hA5}};
    e_tag0[7] = 20'h0; e_tag1[7] = 20'h0;
    e_tag0[5] = {1'b1, 19'd10}; e_tag1[5] = {1'b1, 19'd11}; lru_a[5] = 1;
    for (int i = 0; i < 512; i++) begin
      r_tag0[i] = e_tag0[i]; r_tag1[i] = e_tag1[i]; r_d0[i] = e_d0[i]; r_d1[i] = e_d1[i];
    end

    rst = 1; irq = 0; l2_busy = 0; l2_addr = '0;
    repeat (2) @(negedge clk);
    chk({ic_en, l2_rdy, mem_req, we0, we1} == 5'b0, "reset_ctrl", {ic_en, l2_rdy, mem_req, we0, we1}, 0);
    chk(data_wd_l2 == 0 && l2_data_wd == 0, "reset_data", data_wd_l2, 0);
    chk(mem_addr == 0 && l2_tag_wd == 0 && l2_index == 0, "reset_addr", {mem_addr, l2_tag_wd, l2_index}, 0);
    rst = 0;
    @(negedge clk);

    do_req({19'd9, 9'd6}, 0, 2, 0);    // hit way1
    do_req({19'd3, 9'd7}, 0, 2, 0);    // miss, both invalid -> way0
    do_req({19'd12, 9'd5}, 0, 2, 0);   // miss, both valid, lru=1 -> way1
    do_req({19'd9, 9'd6}, 4, 6, 0);    // busy for 4 cycles, hold 6
    for (int n = 0; n < 40; n++) begin
      a = {19'($urandom % 4), 9'($urandom % 4)};
      b = ($urandom % 4 == 0) ? int'($urandom_range(1, 4)) : 0;
      do_req(a, b, 1 + int'($urandom % 6), (b == 0) && ($urandom % 6 == 0));
    end

    // Reset while waiting on memory; a late ack must not cause a fill or response.
    resp_en = 0;
    a = {19'd7, 9'd2};
    cur_addr = a; cur_miss = 1;
    l2_addr = a; irq = 1;
    t = 0;
    while (!mem_req && t < 50) begin @(negedge clk); t++; end
    chk(mem_req, "reach_mem_req", mem_req, 1);
    rst = 1; irq = 0;
    @(negedge clk);
    chk({ic_en, l2_rdy, mem_req, we0, we1} == 5'b0, "mid_reset_ctrl", {ic_en, l2_rdy, mem_req, we0, we1}, 0);
    rst = 0;
    mem_rd_data = mem_word(a);
    mem_ack = 1;
    @(negedge clk);
    mem_ack = 0;
    repeat (4) begin
      @(negedge clk);
      chk({ic_en, l2_rdy, mem_req, we0, we1} == 5'b0, "late_ack_ignored", {ic_en, l2_rdy, mem_req, we0, we1}, 0);
    end
    resp_en = 1;
    do_req({19'd1, 9'd3}, 0, 1, 0);
    repeat (5) @(negedge clk);
    chk(rq.size() == 0 && fq.size() == 0, "queues_drained", rq.size() + fq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/l2_ic_resp.md
# l2_ic_resp

L2-side responder for I-Cache refill requests: accepts an I-Cache block request, looks up the 2-way L2 tag/data arrays, fetches from main memory on an L2 miss, and returns one 128-bit block with a ready pulse. It sits between the I-Cache controller's L2 port and the L2 arrays and memory interface. It also serves as the grant point whenever the L2 is owned by another requester.

## Interface
- No parameters; widths are fixed by the 28-bit block address (9-bit L2 index, 19-bit L2 tag).
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- irq  in  1  I-Cache request; held high by requester until its L1 write completes
- l2_addr  in  28  requested block address
- l2_busy  in  1  L2 owned by another requester (D-Cache path)
- ic_en  out  1  L2 granted to I-Cache for the current request
- l2_rdy  out  1  one-cycle pulse: data_wd_l2 valid
- data_wd_l2  out  128  returned block
- l2_index  out  9  L2 set index (l2_addr[8:0])
- l2_tag0_rd, l2_tag1_rd  in  20  {valid, tag[18:0]} of way0/way1; valid one cycle after l2_index
- l2_data0_rd, l2_data1_rd  in  128  way0/way1 data; same latency
- l2_lru  in  1  replacement mark for the set
- l2_block0_we, l2_block1_we  out  1  way write enables
- l2_tag_wd  out  20  {1'b1, l2_addr[27:9]}
- l2_data_wd  out  128  fill data
- mem_req  out  1  memory read request
- mem_addr  out  28  memory block address
- mem_ack  in  1  memory data valid, single cycle
- mem_rd_data  in  128  memory block

## Operation
- States: IDLE, WAIT_BUSY, LOOKUP, COMPARE, MEM_REQ, FILL, RESP, HOLD.
- IDLE: irq & !l2_busy -> latch l2_addr, drive l2_index, go LOOKUP. irq & l2_busy -> WAIT_BUSY.
- WAIT_BUSY: ic_en low; go LOOKUP (latching addr) once l2_busy low; go IDLE if irq drops.
- LOOKUP: array read in flight.
- COMPARE: hit on way w = valid & tag match; way0 has priority. Hit -> register way data into data_wd_l2, go RESP. Miss -> go MEM_REQ.
- MEM_REQ: mem_req=1, mem_addr=latched addr, held until mem_ack. A mem_ack in the first cycle of mem_req is accepted. On mem_ack, capture mem_rd_data into data_wd_l2 and go FILL.
- FILL: one cycle. Assert exactly one we; l2_data_wd=data_wd_l2. Way choice: way0 invalid -> way0; else way1 invalid -> way1; else l2_lru=0 -> way0, 1 -> way1. Then go RESP.
- RESP: l2_rdy=1 for one cycle, then go HOLD.
- HOLD: data_wd_l2 and ic_en held until irq low, then go IDLE. A new request is accepted no earlier than the cycle after irq is sampled low.
- ic_en=1 in LOOKUP through HOLD. l2_busy changes after grant are ignored.
- irq dropping before RESP: any pending memory fetch and fill still complete, l2_rdy is suppressed, and the block returns to IDLE.

## Timing
- Reset: state IDLE; all outputs 0, including data_wd_l2. Reset mid-operation drops mem_req and we in the next cycle. The memory side tolerates an abandoned request.
- irq sampled at edge N in IDLE with l2_busy low: ic_en high from N+1.
  - Hit: l2_rdy during cycle N+3.
  - Miss: mem_req from N+3; mem_ack at cycle M; FILL at M+1; l2_rdy at M+2.
- data_wd_l2 is stable from l2_rdy until irq is sampled low.

## Configuration
- L2_EARLY_RESP_EN defined: l2_rdy is asserted in the FILL cycle, concurrent with the L2 write. Miss latency becomes mem_ack+1, and the RESP state is skipped.
- Undefined: l2_rdy comes after FILL, as specified above.

## Test plan
- Hit way1: tag1={1,tagA}, tag0 invalid, data1=128'hA5.., irq at N -> ic_en at N+1, l2_rdy single pulse at N+3, data_wd_l2=data1, no we, no mem_req.
- Miss, both ways invalid: mem_ack 5 cycles after mem_req with data 128'h1234.. -> mem_addr=l2_addr, l2_block0_we pulse with l2_tag_wd={1,addr[27:9]}, l2_rdy at ack+2 (ack+1 with L2_EARLY_RESP_EN).
- Miss, both valid, l2_lru=1 -> only l2_block1_we asserted.
- l2_busy high 4 cycles while irq high -> ic_en low throughout; lookup starts in the cycle after l2_busy falls.
- After l2_rdy, irq held 6 cycles -> ic_en and data_wd_l2 held; second irq accepted only after irq sampled low.
- rst asserted during MEM_REQ -> mem_req, ic_en, l2_rdy, we all 0 next cycle; a late mem_ack is ignored.
